rtc_calendar: RTL and testbench

RTC_CALENDAR -- requirements
Module: rtc_calendar

---
 rtl/rtc_pkg.sv | 31 +++
 rtl/rtc_bcd_counter.sv | 45 ++++
 rtl/rtc_calendar.sv | 151 +++++++++++++++
 tb/tb_rtc_calendar.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC constants: register word indices, field widths and BCD limits.
// Imported by the calendar top and its BCD counter sub-module.
package rtc_pkg;

  typedef enum logic [4:0] {
    REG_SEC    = 5'h00,
    REG_MIN    = 5'h01,
    REG_HOUR   = 5'h02,
    REG_DAY    = 5'h03,
    REG_CTRL   = 5'h04,
    REG_STATUS = 5'h05,
    REG_ALARM0 = 5'h08
  } rtc_reg_e;

  localparam int BCD_W       = 8;
  localparam int DAY_W       = 16;
  localparam int TIME_W      = 3 * BCD_W;
  localparam int CTRL_IE_LSB = 4;
  localparam int ALARM_EN    = 31;

  localparam logic [BCD_W-1:0] SEC_MAX_BCD  = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX_BCD  = 8'h59;
  localparam logic [BCD_W-1:0] HOUR_MAX_BCD = 8'h23;

  // Both nibbles must be decimal; with valid nibbles BCD orders like binary.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] value,
                                     input logic [BCD_W-1:0] max_bcd);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max_bcd);
  endfunction

endpackage

// File: rtl/rtc_bcd_counter.sv
// Two-digit packed-BCD counter wrapping at MAX_BCD, with a load port that
// overrides the increment and suppresses the carry on that edge.
module rtc_bcd_counter
  import rtc_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_BCD = 8'h59
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  output logic [BCD_W-1:0] value_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] inc_val;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    inc_val = value_o + 8'd1;
    if (value_o == MAX_BCD) begin
      inc_val = '0;
    end else if (value_o[3:0] == 4'd9) begin
      inc_val = {value_o[7:4] + 4'd1, 4'd0};
    end
  end

  // A loaded field did not wrap, so it must not carry into the next field.
  assign carry_o = inc_i && !load_i && (value_o == MAX_BCD);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      value_o <= '0;
    end else if (load_i) begin
      value_o <= load_val_i;
    end else if (inc_i) begin
      value_o <= inc_val;
    end
  end

endmodule

// File: rtl/rtc_calendar.sv
// Wishbone real-time clock: BCD time of day, binary day counter, prescaler,
// and NUM_ALARMS alarm channels with maskable level interrupt.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int NUM_ALARMS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o
);

  localparam int PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_FREQ - 1);

  logic [PRESC_W-1:0]    presc_q;
  logic                  run_q, tick, tick_q;
  logic [NUM_ALARMS-1:0] ie_q, pending_q, alarm_hit, status_clr, alarm_en_q;
  logic [TIME_W-1:0]     alarm_time_q [NUM_ALARMS];
  logic [BCD_W-1:0]      sec_q, min_q, hour_q;
  logic [DAY_W-1:0]      day_q, day_wval;
  logic                  sec_carry, min_carry, hour_carry;
  logic [4:0]            reg_idx;
  logic                  bus_req, wr_en, lane0_wr, day_we;
  logic                  sec_load, min_load, hour_load;
  logic                  unused_bits;

  assign reg_idx  = adr_i[6:2];
  assign bus_req  = cyc_i && stb_i && !ack_o;
  assign wr_en    = bus_req && we_i;
  assign lane0_wr = wr_en && sel_i[0];

  // Out-of-range or non-decimal time writes are simply never loaded.
  assign sec_load  = lane0_wr && (reg_idx == REG_SEC)  && bcd_valid(dat_i[7:0], SEC_MAX_BCD);
  assign min_load  = lane0_wr && (reg_idx == REG_MIN)  && bcd_valid(dat_i[7:0], MIN_MAX_BCD);
  assign hour_load = lane0_wr && (reg_idx == REG_HOUR) && bcd_valid(dat_i[7:0], HOUR_MAX_BCD);

  assign day_we   = wr_en && (reg_idx == REG_DAY) && (sel_i[1:0] != 2'b00);
  assign day_wval = {sel_i[1] ? dat_i[15:8] : day_q[15:8],
                     sel_i[0] ? dat_i[7:0]  : day_q[7:0]};

  assign tick       = run_q && (presc_q == PRESC_LAST);
  assign status_clr = (lane0_wr && (reg_idx == REG_STATUS)) ? dat_i[NUM_ALARMS-1:0] : '0;

  rtc_bcd_counter #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
    .clk_i, .rst_i, .inc_i(tick), .load_i(sec_load), .load_val_i(dat_i[7:0]),
    .value_o(sec_q), .carry_o(sec_carry)
  );

  rtc_bcd_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
    .clk_i, .rst_i, .inc_i(sec_carry), .load_i(min_load), .load_val_i(dat_i[7:0]),
    .value_o(min_q), .carry_o(min_carry)
  );

  rtc_bcd_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
    .clk_i, .rst_i, .inc_i(min_carry), .load_i(hour_load), .load_val_i(dat_i[7:0]),
    .value_o(hour_q), .carry_o(hour_carry)
  );

  // Alarms compare against the time settled after a tick edge, so bus writes
  // to the time registers alone never raise a match.
  always_comb begin
    alarm_hit = '0;
    for (int n = 0; n < NUM_ALARMS; n++) begin
      alarm_hit[n] = tick_q && alarm_en_q[n] && ({hour_q, min_q, sec_q} == alarm_time_q[n]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o     <= 1'b0;
      irq_o     <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      run_q     <= 1'b0;
      ie_q      <= '0;
      pending_q <= '0;
      day_q     <= '0;
    end else begin
      ack_o  <= bus_req;
      tick_q <= tick;
      if (sec_load) begin
        presc_q <= '0;
      end else if (run_q) begin
        presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      end
      if (lane0_wr && (reg_idx == REG_CTRL)) begin
        run_q <= dat_i[0];
        ie_q  <= dat_i[CTRL_IE_LSB +: NUM_ALARMS];
      end
      if (day_we) begin
        day_q <= day_wval;
      end else if (hour_carry) begin
        day_q <= day_q + 16'd1;
      end
      pending_q <= (pending_q & ~status_clr) | alarm_hit;
      irq_o     <= |(pending_q & ie_q);
    end
  end

  // NOTE: the alarm array is a handful of flops, not a RAM, so it takes the
  // async reset like any other register and reads back zero after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alarm_en_q <= '0;
      for (int n = 0; n < NUM_ALARMS; n++) alarm_time_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_ALARMS; n++) begin
        if (wr_en && (reg_idx == 5'(REG_ALARM0) + 5'(n))) begin
          for (int b = 0; b < 3; b++) begin
            if (sel_i[b]) alarm_time_q[n][8*b +: 8] <= dat_i[8*b +: 8];
          end
          if (sel_i[3]) alarm_en_q[n] <= dat_i[ALARM_EN];
        end
      end
    end
  end

  always_comb begin
    dat_o = '0;
    case (reg_idx)
      REG_SEC:    dat_o[BCD_W-1:0] = sec_q;
      REG_MIN:    dat_o[BCD_W-1:0] = min_q;
      REG_HOUR:   dat_o[BCD_W-1:0] = hour_q;
      REG_DAY:    dat_o[DAY_W-1:0] = day_q;
      REG_CTRL: begin
        dat_o[0]                          = run_q;
        dat_o[CTRL_IE_LSB +: NUM_ALARMS]  = ie_q;
      end
      REG_STATUS: dat_o[NUM_ALARMS-1:0] = pending_q;
      default:    dat_o = '0;
    endcase
    for (int n = 0; n < NUM_ALARMS; n++) begin
      if (reg_idx == 5'(REG_ALARM0) + 5'(n)) begin
        dat_o = {alarm_en_q[n], 7'd0, alarm_time_q[n]};
      end
    end
  end

  assign unused_bits = ^{adr_i[31:7], adr_i[1:0], dat_i[30:24]};

endmodule

// File: tb/tb_rtc_calendar.sv
// Self-checking bench for rtc_calendar at CLOCK_FREQ=4: expected values are
// queued when a transaction or probe is issued and compared when data returns.
module tb_rtc_calendar;

  localparam int CLOCK_FREQ = 4;
  localparam int NUM_ALARMS = 2;

  localparam logic [31:0] A_SEC    = 32'h00;
  localparam logic [31:0] A_MIN    = 32'h04;
  localparam logic [31:0] A_HOUR   = 32'h08;
  localparam logic [31:0] A_DAY    = 32'h0C;
  localparam logic [31:0] A_CTRL   = 32'h10;
  localparam logic [31:0] A_STATUS = 32'h14;
  localparam logic [31:0] A_UNMAP  = 32'h18;
  localparam logic [31:0] A_ALARM0 = 32'h20;
  localparam logic [31:0] A_ALARM1 = 32'h24;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  rtc_calendar #(.CLOCK_FREQ(CLOCK_FREQ), .NUM_ALARMS(NUM_ALARMS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Starts at a negedge; returns one idle cycle after the acknowledge.
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!ack_o && lat < 16);
    rdata = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0;
    @(negedge clk_i);
  endtask

  task automatic wb_write_sel(input string tag, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    int          lat;
    wb_cycle(1'b1, adr, dat, sel, rd, lat);
    check({tag, "_ack"}, 32'(lat), 32'd1);
  endtask

  task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat);
    wb_write_sel(tag, adr, dat, 4'hF);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    sb_entry_t   e;
    logic [31:0] rd;
    int          lat;
    sb_q.push_back('{tag, exp});
    wb_cycle(1'b0, adr, 32'd0, 4'hF, rd, lat);
    check({tag, "_ack"}, 32'(lat), 32'd1);
    e = sb_q.pop_front();
    check(e.tag, rd, e.exp);
  endtask

  // Combinational read-back without a bus cycle.
  task automatic peek(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    sb_entry_t e;
    sb_q.push_back('{tag, exp});
    adr_i = adr;
    #1;
    e = sb_q.pop_front();
    check(e.tag, dat_o, e.exp);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycles(2);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    peek("rst_sec_peek", A_SEC, 32'h0);
    rst_i = 1'b1;
    cycles(1);
    wb_read("rd_sec0", A_SEC, 32'h0);
    wb_read("rd_min0", A_MIN, 32'h0);
    wb_read("rd_hour0", A_HOUR, 32'h0);
    wb_read("rd_day0", A_DAY, 32'h0);
    wb_read("rd_ctrl0", A_CTRL, 32'h0);
    wb_read("rd_status0", A_STATUS, 32'h0);
    wb_read("rd_alarm0_0", A_ALARM0, 32'h0);
    wb_read("rd_alarm1_0", A_ALARM1, 32'h0);

    // First tick four cycles after RUN, then one minute of ticks
    wb_write("run_on", A_CTRL, 32'h1);
    cycles(2);
    peek("sec_before_tick", A_SEC, 32'h00);
    cycles(1);
    peek("sec_first_tick", A_SEC, 32'h01);
    cycles(236);
    peek("sec_60s", A_SEC, 32'h00);
    peek("min_60s", A_MIN, 32'h01);

    // Full rollover of every field on one tick
    wb_write("halt1", A_CTRL, 32'h0);
    wb_write("wr_hour23", A_HOUR, 32'h23);
    wb_write("wr_min59", A_MIN, 32'h59);
    wb_write("wr_sec59", A_SEC, 32'h59);
    wb_write("wr_dayffff", A_DAY, 32'hFFFF);
    wb_write("run_roll", A_CTRL, 32'h1);
    cycles(2);
    peek("sec_pre_roll", A_SEC, 32'h59);
    cycles(1);
    peek("sec_roll", A_SEC, 32'h00);
    peek("min_roll", A_MIN, 32'h00);
    peek("hour_roll", A_HOUR, 32'h00);
    peek("day_roll", A_DAY, 32'h0000);

    // Illegal BCD, byte lanes and unmapped offsets
    wb_write("halt2", A_CTRL, 32'h0);
    wb_write("wr_sec5a", A_SEC, 32'h5A);
    peek("sec_after_5a", A_SEC, 32'h00);
    wb_write("wr_sec60", A_SEC, 32'h60);
    peek("sec_after_60", A_SEC, 32'h00);
    wb_write("wr_hour24", A_HOUR, 32'h24);
    peek("hour_after_24", A_HOUR, 32'h00);
    wb_write_sel("wr_min_nolane", A_MIN, 32'h37, 4'b1110);
    peek("min_nolane", A_MIN, 32'h00);
    wb_write_sel("wr_day_lane1", A_DAY, 32'h1234, 4'b0010);
    peek("day_lane1", A_DAY, 32'h1200);
    wb_write("wr_unmapped", A_UNMAP, 32'hFFFF_FFFF);
    wb_read("rd_unmapped", A_UNMAP, 32'h0);
    wb_write("wr_ctrl_ones", A_CTRL, 32'hFFFF_FFF0);
    wb_read("rd_ctrl_ones", A_CTRL, 32'h30);
    wb_write("halt3", A_CTRL, 32'h0);

    // SEC write on the tick edge wins, suppresses carry, restarts prescaler
    wb_write("wr_sec59b", A_SEC, 32'h59);
    wb_write("run_coll", A_CTRL, 32'h1);
    cycles(2);
    wb_write("wr_sec10_tick", A_SEC, 32'h10);
    peek("sec_coll", A_SEC, 32'h10);
    peek("min_coll", A_MIN, 32'h00);
    cycles(2);
    peek("sec_coll_hold", A_SEC, 32'h10);
    cycles(1);
    peek("sec_coll_next", A_SEC, 32'h11);
    cycles(1);
    wb_write("wr_sec20_mid", A_SEC, 32'h20);
    cycles(2);
    peek("sec_presc_clr_hold", A_SEC, 32'h20);
    cycles(1);
    peek("sec_presc_clr_tick", A_SEC, 32'h21);

    // Alarm 0 at 00:00:05 raises pending and irq; alarm 1 is disabled
    wb_write("halt4", A_CTRL, 32'h0);
    wb_write("wr_sec00", A_SEC, 32'h00);
    wb_write("wr_min00", A_MIN, 32'h00);
    wb_write("wr_hour00", A_HOUR, 32'h00);
    wb_write("wr_alarm0", A_ALARM0, 32'h8000_0005);
    wb_write("wr_alarm1", A_ALARM1, 32'h0000_0003);
    wb_read("rd_alarm0", A_ALARM0, 32'h8000_0005);
    wb_read("rd_alarm1", A_ALARM1, 32'h0000_0003);
    wb_write("run_ie0", A_CTRL, 32'h11);
    cycles(12);
    peek("status_alarm1_off", A_STATUS, 32'h0);
    cycles(7);
    peek("sec_alarm", A_SEC, 32'h05);
    peek("status_pre_set", A_STATUS, 32'h0);
    cycles(1);
    peek("status_set", A_STATUS, 32'h1);
    cycles(1);
    check("irq_high", {31'd0, irq_o}, 32'd1);
    wb_write("wr_status_clr", A_STATUS, 32'h1);
    check("irq_cleared", {31'd0, irq_o}, 32'd0);
    peek("status_cleared", A_STATUS, 32'h0);

    // Reset while the acknowledge is high
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = A_SEC; sel_i = 4'hF;
    cycles(1);
    check("ack_before_rst", {31'd0, ack_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("ack_abort", {31'd0, ack_o}, 32'd0);
    check("irq_in_rst", {31'd0, irq_o}, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0; sel_i = '0;
    cycles(10);
    peek("rst_sec", A_SEC, 32'h0);
    peek("rst_ctrl", A_CTRL, 32'h0);
    peek("rst_day", A_DAY, 32'h0);
    peek("rst_alarm0", A_ALARM0, 32'h0);
    peek("rst_status", A_STATUS, 32'h0);
    cycles(1);
    rst_i = 1'b1;
    cycles(1);
    wb_read("post_rst_ctrl", A_CTRL, 32'h0);
    wb_read("post_rst_sec", A_SEC, 32'h0);
    cycles(8);
    peek("post_rst_no_advance", A_SEC, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
